// File: rtl/fetch_pc_unit.sv
// Fetch PC holder and instruction-memory request sequencer for the IF stage.
// Ports: CLK/RST; STALL, BRANCH_TAKEN, NEXT_PC in; SEQ_PC, PC_SEL to the
// next-PC mux; IMEM_REQ/ADDR/GNT/RVALID/RDATA memory side; INSTR_VALID,
// INSTR_OUT, PC_OUT to the IF/ID register.
module fetch_pc_unit #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               INSTR_BYTES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STALL,
    input  logic             BRANCH_TAKEN,
    input  logic [WIDTH-1:0] NEXT_PC,
    output logic [WIDTH-1:0] SEQ_PC,
    output logic             PC_SEL,
    output logic             IMEM_REQ,
    output logic [WIDTH-1:0] IMEM_ADDR,
    input  logic             IMEM_GNT,
    input  logic             IMEM_RVALID,
    input  logic [WIDTH-1:0] IMEM_RDATA,
    output logic             INSTR_VALID,
    output logic [WIDTH-1:0] INSTR_OUT,
    output logic [WIDTH-1:0] PC_OUT
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_nx;
    logic             kill;
    logic             kill_nx;
    logic             capture;

    assign SEQ_PC      = pc + WIDTH'(INSTR_BYTES);
    assign PC_SEL      = BRANCH_TAKEN;
    assign IMEM_ADDR   = pc;
    assign IMEM_REQ    = (state == REQ);
    assign INSTR_VALID = (state == HOLD);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        kill_nx  = kill;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = REQ;
                if (BRANCH_TAKEN) pc_nx = NEXT_PC;
            end
            REQ: begin
                if (BRANCH_TAKEN) pc_nx = NEXT_PC;
                if (IMEM_GNT) begin
                    state_nx = WAIT;
                    // A redirect racing the grant poisons that response.
                    kill_nx  = BRANCH_TAKEN;
                end
            end
            WAIT: begin
                if (BRANCH_TAKEN) begin
                    pc_nx = NEXT_PC;
                    if (IMEM_RVALID) begin
                        state_nx = REQ;
                        kill_nx  = 1'b0;
                    end else begin
                        kill_nx  = 1'b1;
                    end
                end else if (IMEM_RVALID) begin
                    kill_nx = 1'b0;
                    if (kill) begin
                        state_nx = REQ;
                    end else begin
                        state_nx = HOLD;
                        capture  = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Branch wins over STALL; a plain consume takes SEQ_PC.
                if (BRANCH_TAKEN || !STALL) begin
                    pc_nx    = NEXT_PC;
                    state_nx = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            INSTR_OUT <= '0;
            PC_OUT    <= RESET_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            kill  <= kill_nx;
            if (capture) begin
                INSTR_OUT <= IMEM_RDATA;
                PC_OUT    <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table followed by
// randomized traffic checked against a program-order fetch model.
module tb_fetch_pc_unit;

    logic        CLK;
    logic        RST;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] NEXT_PC;
    logic [31:0] SEQ_PC;
    logic        PC_SEL;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        INSTR_VALID;
    logic [31:0] INSTR_OUT;
    logic [31:0] PC_OUT;

    logic [31:0] target;

    // The bench plays the next-PC mux.
    assign NEXT_PC = PC_SEL ? target : SEQ_PC;

    fetch_pc_unit #(
        .WIDTH      (32),
        .RESET_PC   (32'h0),
        .INSTR_BYTES(4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .STALL       (STALL),
        .BRANCH_TAKEN(BRANCH_TAKEN),
        .NEXT_PC     (NEXT_PC),
        .SEQ_PC      (SEQ_PC),
        .PC_SEL      (PC_SEL),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_OUT   (INSTR_OUT),
        .PC_OUT      (PC_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
    endfunction

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] tgt;
        logic        st;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eiv;
        logic [31:0] eout;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic rst, input logic gnt, input logic rv,
                     input logic [31:0] rdata, input logic br,
                     input logic [31:0] tgt, input logic st,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic eiv, input logic [31:0] eout,
                     input logic [31:0] epc);
        vec_t t;
        t.rst = rst; t.gnt = gnt; t.rv = rv; t.rdata = rdata;
        t.br = br; t.tgt = tgt; t.st = st;
        t.ereq = ereq; t.eaddr = eaddr; t.eiv = eiv;
        t.eout = eout; t.epc = epc;
        tbl.push_back(t);
    endtask

    localparam logic [31:0] DA = 32'h1111_1111;
    localparam logic [31:0] DB = 32'h2222_2222;
    localparam logic [31:0] DC = 32'h3333_3333;
    localparam logic [31:0] DD = 32'h4444_4444;
    localparam logic [31:0] DE = 32'h5555_5555;
    localparam logic [31:0] DF = 32'h6666_6666;
    localparam logic [31:0] DG = 32'h7777_7777;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;
    localparam logic [31:0] TOP = 32'hFFFF_FFFC;

    // Random-phase state
    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pend;
    int          pend_cnt;
    logic        drop_due;
    logic        prev_iv;
    int          delivered;

    initial begin
        n_chk = 0;
        n_fail = 0;
        RST = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; target = '0;
        IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;

        // rst gnt rv rdata br tgt st | req addr iv out pc_out
        v(1,0,0,0,  0,0,0,     0,0,0,0,0);
        v(0,0,0,0,  0,0,0,     1,0,0,0,0);
        v(0,1,0,0,  0,0,0,     0,0,0,0,0);
        v(0,0,1,DA, 0,0,0,     0,0,1,DA,0);
        v(0,0,0,0,  0,0,0,     1,4,0,DA,0);
        v(0,1,0,0,  0,0,0,     0,4,0,DA,0);
        v(0,0,1,DB, 0,0,0,     0,4,1,DB,4);
        for (int i = 0; i < 5; i++)
            v(0,0,0,0, 0,0,1,  0,4,1,DB,4);
        v(0,0,0,0,  0,0,0,     1,8,0,DB,4);
        v(0,1,0,0,  0,0,0,     0,8,0,DB,4);
        v(0,0,1,DC, 0,0,0,     0,8,1,DC,8);
        v(0,0,0,0,  1,32'h100,1, 1,32'h100,0,DC,8);
        v(0,0,0,0,  0,0,0,     1,32'h100,0,DC,8);
        v(0,1,0,0,  0,0,0,     0,32'h100,0,DC,8);
        v(0,0,0,0,  1,32'h200,0, 0,32'h200,0,DC,8);
        v(0,0,0,0,  0,0,0,     0,32'h200,0,DC,8);
        v(0,0,0,0,  0,0,0,     0,32'h200,0,DC,8);
        v(0,0,1,BAD,0,0,0,     1,32'h200,0,DC,8);
        v(0,1,0,0,  0,0,0,     0,32'h200,0,DC,8);
        v(0,0,1,DD, 0,0,0,     0,32'h200,1,DD,32'h200);
        v(0,0,0,0,  1,TOP,0,   1,TOP,0,DD,32'h200);
        v(0,1,0,0,  0,0,0,     0,TOP,0,DD,32'h200);
        v(0,0,1,DE, 0,0,0,     0,TOP,1,DE,TOP);
        v(0,0,0,0,  0,0,0,     1,0,0,DE,TOP);
        v(0,1,0,0,  0,0,0,     0,0,0,DE,TOP);
        v(1,0,1,DF, 0,0,0,     0,0,0,0,0);
        v(0,0,1,DF, 0,0,0,     1,0,0,0,0);
        v(0,0,1,DF, 0,0,0,     1,0,0,0,0);
        v(0,1,0,0,  1,32'h300,0, 0,32'h300,0,0,0);
        v(0,0,1,BAD,0,0,0,     1,32'h300,0,0,0);
        v(0,1,0,0,  0,0,0,     0,32'h300,0,0,0);
        v(0,0,1,BAD,1,32'h400,0, 1,32'h400,0,0,0);
        v(0,1,0,0,  0,0,0,     0,32'h400,0,0,0);
        v(0,0,1,DG, 0,0,0,     0,32'h400,1,DG,32'h400);
        v(0,1,1,DF, 0,0,1,     0,32'h400,1,DG,32'h400);
        v(0,0,0,0,  0,0,0,     1,32'h404,0,DG,32'h400);

        for (int i = 0; i < tbl.size(); i++) begin
            RST = tbl[i].rst;
            IMEM_GNT = tbl[i].gnt;
            IMEM_RVALID = tbl[i].rv;
            IMEM_RDATA = tbl[i].rdata;
            BRANCH_TAKEN = tbl[i].br;
            target = tbl[i].tgt;
            STALL = tbl[i].st;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d imem_req", i), 32'(IMEM_REQ),
                32'(tbl[i].ereq));
            chk($sformatf("v%0d imem_addr", i), IMEM_ADDR, tbl[i].eaddr);
            chk($sformatf("v%0d seq_pc", i), SEQ_PC, tbl[i].eaddr + 4);
            chk($sformatf("v%0d instr_valid", i), 32'(INSTR_VALID),
                32'(tbl[i].eiv));
            chk($sformatf("v%0d instr_out", i), INSTR_OUT, tbl[i].eout);
            chk($sformatf("v%0d pc_out", i), PC_OUT, tbl[i].epc);
        end

        // Randomized traffic
        RST = 1'b1; IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0;
        BRANCH_TAKEN = 1'b0; STALL = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_pc = 32'h0;
        pend = 1'b0;
        pend_cnt = 0;
        pend_addr = '0;
        drop_due = 1'b0;
        prev_iv = 1'b0;
        delivered = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic        br;
            logic        st;
            logic        gnt;
            logic        rv;
            logic [31:0] rd;
            logic [31:0] tg;

            if (drop_due)
                chk("rnd drop", 32'(INSTR_VALID), 32'h0);
            if (INSTR_VALID) begin
                if (!prev_iv) delivered++;
                chk("rnd pc_out", PC_OUT, exp_pc);
                chk("rnd instr_out", INSTR_OUT, mem_word(exp_pc));
                chk("rnd req_in_hold", 32'(IMEM_REQ), 32'h0);
            end
            if (IMEM_REQ) begin
                chk("rnd imem_addr", IMEM_ADDR, exp_pc);
                chk("rnd seq_pc", SEQ_PC, exp_pc + 32'd4);
            end

            br = ($urandom % 10) == 0;
            st = ($urandom % 2) == 1;
            tg = (($urandom % 6) == 0) ? TOP : ($urandom & 32'hFFFF_FFFC);
            gnt = IMEM_REQ ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
            rv = 1'b0;
            rd = $urandom;
            if (pend) begin
                if (pend_cnt == 1) begin
                    rv = 1'b1;
                    rd = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end else if ((IMEM_REQ || INSTR_VALID) && ($urandom % 4) == 0) begin
                rv = 1'b1;
            end
            if (IMEM_REQ && gnt) begin
                pend = 1'b1;
                pend_addr = IMEM_ADDR;
                pend_cnt = $urandom_range(1, 3);
            end

            BRANCH_TAKEN = br;
            target = tg;
            STALL = st;
            IMEM_GNT = gnt;
            IMEM_RVALID = rv;
            IMEM_RDATA = rd;
            #1;
            chk("rnd pc_sel", 32'(PC_SEL), 32'(br));

            drop_due = INSTR_VALID && (br || !st);
            if (br)
                exp_pc = tg;
            else if (INSTR_VALID && !st)
                exp_pc = exp_pc + 32'd4;
            prev_iv = INSTR_VALID;

            @(posedge CLK);
            #1;
        end

        chk("rnd progress", 32'(delivered >= 100), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
